// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every input vector of a combinational chip in
// ascending order, waits SETTLE cycles per vector, compares the chip output
// against the TRUTH table and reports a pass/fail summary.
// Optional build macro: GATE_SWEEP_STOP_ON_FAIL_EN -- when defined, the first
// mismatching vector ends the sweep on its compare edge.
module gate_sweep_checker #(
  parameter int IN_W   = 1,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1,
  parameter logic [OUT_W*(2**IN_W)-1:0] TRUTH = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IN_W:0]    fail_count,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
  localparam logic [IN_W-1:0]  LAST_VEC  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] settle_cnt;
  logic             accept;
  logic             expire;
  logic             mismatch;
  logic             last_vec;
  logic             finish;
  logic [OUT_W-1:0] expected;
  logic [IN_W:0]    fail_next;

  // Decode the sweep events for the current cycle and the next FSM state.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    expire     = 1'b0;
    expected   = TRUTH[int'(dut_in) * OUT_W +: OUT_W];
    last_vec   = (dut_in == LAST_VEC);
    mismatch   = 1'b0;
    finish     = 1'b0;
    fail_next  = fail_count;

    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // A start here is ignored: the sweep in flight always completes.
        expire   = (settle_cnt == CNT_W'(1));
        mismatch = expire && (dut_out != expected);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        finish   = expire && (last_vec || mismatch);
`else
        finish   = expire && last_vec;
`endif
        if (finish) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase

    fail_next = fail_count + {{IN_W{1'b0}}, mismatch};
  end

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Vector, settle counter and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dut_in           <= '0;
      settle_cnt       <= '0;
      fail_count       <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else if (accept) begin
      dut_in           <= '0;
      settle_cnt       <= SETTLE_LD;
      fail_count       <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else if (expire) begin
      fail_count <= fail_next;
      if (mismatch && !first_fail_valid) begin
        first_fail_vec   <= dut_in;
        first_fail_valid <= 1'b1;
      end
      if (finish) begin
        // dut_in holds the last compared vector once the sweep ends.
        done <= 1'b1;
        pass <= (fail_next == '0);
      end else begin
        dut_in     <= dut_in + 1'b1;
        settle_cnt <= SETTLE_LD;
      end
    end else if (state == RUN) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a Not chip, a buffer chip and an
// And chip (with an optional wrong vector 2) are swept by three instances.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1, start2;
  logic bad2;

  logic       dut_in0, dut_out0, busy0, done0, pass0, ffv0, ffvalid0;
  logic [1:0] fail0;
  logic       dut_in1, dut_out1, busy1, done1, pass1, ffv1, ffvalid1;
  logic [1:0] fail1;
  logic [1:0] dut_in2, ffv2;
  logic       dut_out2, busy2, done2, pass2, ffvalid2;
  logic [2:0] fail2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Chips under test
  assign dut_out0 = ~dut_in0;
  assign dut_out1 = dut_in1;
  assign dut_out2 = (&dut_in2) ^ (bad2 && (dut_in2 == 2'd2));

  gate_sweep_checker u_not (
    .clk(clk), .reset(reset), .start(start0), .dut_in(dut_in0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fail0),
    .first_fail_vec(ffv0), .first_fail_valid(ffvalid0)
  );

  gate_sweep_checker u_buf (
    .clk(clk), .reset(reset), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fail1),
    .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
  );

  gate_sweep_checker #(.IN_W(2), .OUT_W(1), .SETTLE(3), .TRUTH(4'b1000)) u_and (
    .clk(clk), .reset(reset), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_count(fail2),
    .first_fail_vec(ffv2), .first_fail_valid(ffvalid2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    bad2   = 1'b0;
    #12;
    chk("rst_busy",    int'(busy2), 0);
    chk("rst_done",    int'(done2), 0);
    chk("rst_pass",    int'(pass2), 0);
    chk("rst_dut_in",  int'(dut_in2), 0);
    chk("rst_fail",    int'(fail2), 0);
    chk("rst_ffvalid", int'(ffvalid2), 0);
    reset = 1'b0;
    tick();

    // Not and buffer chips, start accepted at edge 0
    start0 = 1'b1;
    start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    chk("not_e0_in",   int'(dut_in0), 0);
    chk("not_e0_busy", int'(busy0), 1);
    tick();
    chk("not_e1_in",   int'(dut_in0), 1);
    chk("not_e1_done", int'(done0), 0);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    chk("buf_e1_done", int'(done1), 1);
    chk("buf_e1_fail", int'(fail1), 1);
    chk("buf_e1_ffv",  int'(ffv1), 0);
    chk("buf_e1_in",   int'(dut_in1), 0);
    chk("buf_e1_pass", int'(pass1), 0);
`else
    chk("buf_e1_done", int'(done1), 0);
`endif
    tick();
    chk("not_e2_done",    int'(done0), 1);
    chk("not_e2_pass",    int'(pass0), 1);
    chk("not_e2_busy",    int'(busy0), 0);
    chk("not_e2_fail",    int'(fail0), 0);
    chk("not_e2_ffvalid", int'(ffvalid0), 0);
`ifndef GATE_SWEEP_STOP_ON_FAIL_EN
    chk("buf_e2_done",    int'(done1), 1);
    chk("buf_e2_pass",    int'(pass1), 0);
    chk("buf_e2_fail",    int'(fail1), 2);
    chk("buf_e2_ffv",     int'(ffv1), 0);
    chk("buf_e2_ffvalid", int'(ffvalid1), 1);
    chk("buf_e2_in",      int'(dut_in1), 1);
`endif

    // Correct And chip, SETTLE=3
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      if (e % 3 == 0 && e < 12) chk($sformatf("and_in_e%0d", e), int'(dut_in2), e / 3);
      if (e < 12) chk($sformatf("and_done_e%0d", e), int'(done2), 0);
      if (e < 12) tick();
    end
    chk("and_done", int'(done2), 1);
    chk("and_pass", int'(pass2), 1);
    chk("and_fail", int'(fail2), 0);
    chk("and_busy", int'(busy2), 0);

    // And chip with vector 2 wrong, stray start mid-sweep
    bad2   = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    tick();
    start2 = 1'b1;
    tick();              // edge 4
    start2 = 1'b0;
    chk("bad_stray_in",   int'(dut_in2), 1);
    chk("bad_stray_busy", int'(busy2), 1);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    for (int e = 5; e <= 9; e++) tick();
    chk("bad_done_e9", int'(done2), 1);
    chk("bad_in_e9",   int'(dut_in2), 2);
`else
    for (int e = 5; e <= 11; e++) tick();
    chk("bad_done_e11", int'(done2), 0);
    tick();
    chk("bad_done_e12", int'(done2), 1);
`endif
    chk("bad_fail",    int'(fail2), 1);
    chk("bad_ffv",     int'(ffv2), 2);
    chk("bad_ffvalid", int'(ffvalid2), 1);
    chk("bad_pass",    int'(pass2), 0);

    // Restart from DONE clears results
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("rs_done",    int'(done2), 0);
    chk("rs_pass",    int'(pass2), 0);
    chk("rs_fail",    int'(fail2), 0);
    chk("rs_ffvalid", int'(ffvalid2), 0);
    chk("rs_ffv",     int'(ffv2), 0);
    chk("rs_in",      int'(dut_in2), 0);
    chk("rs_busy",    int'(busy2), 1);

    // Run past the vector 2 compare, then reset between edges
    for (int e = 1; e <= 10; e++) tick();
    chk("pre_rst_fail", int'(fail2), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",    int'(busy2), 0);
    chk("mid_rst_done",    int'(done2), 0);
    chk("mid_rst_in",      int'(dut_in2), 0);
    chk("mid_rst_fail",    int'(fail2), 0);
    chk("mid_rst_ffv",     int'(ffv2), 0);
    chk("mid_rst_ffvalid", int'(ffvalid2), 0);
    chk("mid_rst_pass",    int'(pass2), 0);
    tick();
    reset = 1'b0;
    bad2  = 1'b0;
    tick();

    // Full sweep after reset
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int e = 1; e <= 11; e++) tick();
    chk("post_done_e11", int'(done2), 0);
    tick();
    chk("post_done", int'(done2), 1);
    chk("post_pass", int'(pass2), 1);
    chk("post_fail", int'(fail2), 0);
    chk("post_in",   int'(dut_in2), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
